// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the program loader.
// master = host/bench side, slave = loader side.
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport master (output in_valid, in_data,
                  input  in_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (input  in_valid, in_data,
                  output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian 16-bit word stream into imem, then raises cpu_run.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum word).
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_run,
  output logic          busy,
  output logic          error
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO,
`ifdef LOADER_CHECKSUM_EN
    S_CHK_HI, S_CHK_LO,
`endif
    S_DONE, S_ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = S_CHK_HI;
`else
  localparam state_t AFTER_DATA = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              run_q, run_d;
  logic              err_q, err_d;
  logic              rdy;
  logic [15:0]       word, hdr;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       chk_q, chk_d;
`endif

  assign word = {hi_q, bus.in_data};
  assign hdr  = {n_q[15:8], bus.in_data};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdy     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR_HI;
          err_d   = 1'b0;
        end
      end
      S_HDR_HI: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          n_d[15:8] = bus.in_data;
          state_d   = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          n_d[7:0] = bus.in_data;
          cnt_d    = 16'd0;
`ifdef LOADER_CHECKSUM_EN
          chk_d    = hdr;
`endif
          if (hdr == 16'd0) state_d = AFTER_DATA;
          else if (hdr > 16'(DEPTH)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else state_d = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          hi_d    = bus.in_data;
          state_d = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = word;
          cnt_d   = cnt_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ word;
`endif
          state_d = (cnt_q + 16'd1 == n_q) ? AFTER_DATA : S_DAT_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK_HI: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          hi_d    = bus.in_data;
          state_d = S_CHK_LO;
        end
      end
      S_CHK_LO: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          if (word == chk_q) state_d = S_DONE;
          else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // One cycle behind DONE entry so the last imem write precedes the CPU release
    run_d = (state_q == S_DONE) && !start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_run        = run_q;
  assign error          = err_q;
  assign busy           = !(state_q inside {S_IDLE, S_DONE, S_ERR});

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios plus randomized loads
// compared against a queue-based model of the expected imem writes and final status.
module tb_imem_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic cpu_run, busy, error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .cpu_run(cpu_run), .busy(busy), .error(error));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_we_cyc = -10, run_rise_cyc = -1;
  logic prev_we = 1'b0, prev_run = 1'b0;
  logic [15:0]       exp_w[$];
  logic [ADDR_W-1:0] obs_addr[$];
  logic [15:0]       obs_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      obs_addr.push_back(bus.imem_addr);
      obs_data.push_back(bus.imem_wdata);
      check("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
      last_we_cyc = cyc;
    end
    if (cpu_run === 1'b1 && !prev_run) run_rise_cyc = cyc;
    prev_we  = bus.imem_we;
    prev_run = cpu_run;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Presents one byte after 0..maxgap idle cycles; optionally pulses start in a gap
  task automatic send_byte(input logic [7:0] b, input int maxgap, input bit ms);
    int g;
    int w;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    bus.in_valid = 1'b0;
    if (ms && busy && ($urandom_range(0, 2) == 0)) begin
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    repeat (g) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  // exp_w holds the words to send; hdr_err/nwr are the expected header verdict and write count
  task automatic run_load(input int n, input int maxgap, input bit ms, input bit bad,
                          input int nwr, input bit hdr_err);
    logic [15:0] nn;
    logic [15:0] x;
    bit fin_err;
    int k;
    nn = n[15:0];
    obs_addr.delete();
    obs_data.delete();
    last_we_cyc  = -10;
    run_rise_cyc = -1;
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_run_clr", {31'd0, cpu_run}, 32'd0);
    check("start_err_clr", {31'd0, error}, 32'd0);
    send_byte(nn[15:8], maxgap, ms);
    send_byte(nn[7:0], maxgap, ms);
    x = nn;
    if (!hdr_err)
      foreach (exp_w[i]) begin
        send_byte(exp_w[i][15:8], maxgap, ms);
        send_byte(exp_w[i][7:0], maxgap, ms);
        x = x ^ exp_w[i];
      end
`ifdef LOADER_CHECKSUM_EN
    if (!hdr_err) begin
      if (bad) x = ~x;
      send_byte(x[15:8], maxgap, ms);
      send_byte(x[7:0], maxgap, ms);
    end
    fin_err = hdr_err | bad;
`else
    fin_err = hdr_err;
`endif
    repeat (4) @(negedge clk);
    check("n_writes", obs_addr.size(), nwr);
    k = (obs_addr.size() < nwr) ? obs_addr.size() : nwr;
    for (int i = 0; i < k; i++) begin
      check("wr_addr", {24'd0, obs_addr[i]}, i);
      check("wr_data", {16'd0, obs_data[i]}, {16'd0, exp_w[i]});
    end
    check("cpu_run_end", {31'd0, cpu_run}, {31'd0, !fin_err});
    check("error_end", {31'd0, error}, {31'd0, fin_err});
    check("busy_end", {31'd0, busy}, 32'd0);
    check("in_ready_end", {31'd0, bus.in_ready}, 32'd0);
    check("we_idle", {31'd0, bus.imem_we}, 32'd0);
    if (nwr > 0) begin
      check("addr_hold", {24'd0, bus.imem_addr}, nwr - 1);
      check("wdata_hold", {16'd0, bus.imem_wdata}, {16'd0, exp_w[nwr-1]});
    end
`ifndef LOADER_CHECKSUM_EN
    if (nwr > 0 && !fin_err) check("run_after_last_we", run_rise_cyc, last_we_cyc + 1);
`endif
  endtask

  typedef struct {
    int          n;
    int          maxgap;
    bit          ms;
    bit          bad;
    logic [15:0] w[3];
    int          nwr;
    bit          hdr_err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tbl[0] = '{3,   0, 1'b0, 1'b0, '{16'h1234, 16'hABCD, 16'hFFFF}, 3,   1'b0};
    tbl[1] = '{0,   0, 1'b0, 1'b0, '{16'h0000, 16'h0000, 16'h0000}, 0,   1'b0};
    tbl[2] = '{257, 0, 1'b0, 1'b0, '{16'h0000, 16'h0000, 16'h0000}, 0,   1'b1};
    tbl[3] = '{2,   5, 1'b1, 1'b0, '{16'h0001, 16'h8000, 16'h0000}, 2,   1'b0};
    tbl[4] = '{1,   0, 1'b0, 1'b0, '{16'h1234, 16'h0000, 16'h0000}, 1,   1'b0};
    tbl[5] = '{1,   0, 1'b0, 1'b1, '{16'h1234, 16'h0000, 16'h0000}, 1,   1'b0};
    tbl[6] = '{256, 1, 1'b0, 1'b0, '{16'h5A5A, 16'hA5A5, 16'h0F0F}, 256, 1'b0};

    #12;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_we", {31'd0, bus.imem_we}, 32'd0);
    check("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_addr_data", {8'd0, bus.imem_addr, bus.imem_wdata}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 7; t++) begin
      exp_w.delete();
      for (int i = 0; i < tbl[t].n && !tbl[t].hdr_err; i++)
        exp_w.push_back(i < 3 ? tbl[t].w[i] : 16'($urandom));
      run_load(tbl[t].n, tbl[t].maxgap, tbl[t].ms, tbl[t].bad, tbl[t].nwr, tbl[t].hdr_err);
    end

    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 8));
      exp_w.delete();
      for (int i = 0; i < n; i++) exp_w.push_back(16'($urandom));
      run_load(n, 5, 1'b1, 1'($urandom_range(0, 1)), n, 1'b0);
    end

    // Asynchronous reset while the loader waits for a low data byte
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'hA5, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("mid_rst_we", {31'd0, bus.imem_we}, 32'd0);
    check("mid_rst_addr_data", {8'd0, bus.imem_addr, bus.imem_wdata}, 32'd0);
    check("mid_rst_status", {29'd0, cpu_run, busy, error}, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_busy", {31'd0, busy}, 32'd0);
    exp_w.delete();
    exp_w.push_back(16'h1234);
    exp_w.push_back(16'hABCD);
    exp_w.push_back(16'hFFFF);
    run_load(3, 0, 1'b0, 1'b0, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
